// File: rtl/data_mem_param.sv
// MEM-stage data memory: word-organised RAM plus a memory-mapped LED register.
// Each access walks IDLE->ACCESS->COMMIT->DONE while clk_stall freezes the pipeline.
module data_mem_param #(
    parameter int          IDX_W    = 10,
    parameter logic [31:0] LED_ADDR = 32'h2000,
    parameter int          LED_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      addr,
    input  logic [31:0]      write_data,
    input  logic             memwrite,
    input  logic             memread,
    input  logic [3:0]       sign_mask,
    output logic [31:0]      read_data,
    output logic [LED_W-1:0] led,
    output logic             clk_stall,
    output logic             mem_fault
);
    typedef enum logic [1:0] {IDLE, ACCESS, COMMIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         mask_q, mask_d;
    logic               wr_q, wr_d;
    logic [31:0]        buf_q, buf_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic               fault_q, fault_d;

    logic [31:0]        mem [0:(1<<IDX_W)-1];

    logic [IDX_W-1:0]   idx;
    logic [1:0]         off;
    logic               is_led;
    logic               bad;
    logic [7:0]         lane8;
    logic [15:0]        half16;
    logic [31:0]        load_val;
    logic [31:0]        merged;
    logic               mem_we;

    assign idx    = addr_q[IDX_W+1:2];
    assign off    = addr_q[1:0];
    assign is_led = (addr_q == LED_ADDR);
    assign lane8  = buf_q[{off, 3'b000} +: 8];
    assign half16 = off[1] ? buf_q[31:16] : buf_q[15:0];

    always_comb begin
        bad      = 1'b0;
        load_val = 32'h0;
        merged   = buf_q;
        case (mask_q[2:0])
            3'b001: begin
                load_val = {{24{mask_q[3] & lane8[7]}}, lane8};
                merged[{off, 3'b000} +: 8] = wdata_q[7:0];
            end
            3'b011: begin
                bad      = off[0];
                load_val = {{16{mask_q[3] & half16[15]}}, half16};
                merged[{off[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            3'b111: begin
                bad      = (off != 2'b00);
                load_val = buf_q;
                merged   = wdata_q;
            end
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        wr_d    = wr_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        led_d   = led_q;
        fault_d = 1'b0;
        case (state_q)
            IDLE: if (memread | memwrite) begin
                addr_d  = addr;
                wdata_d = write_data;
                mask_d  = sign_mask;
                wr_d    = memwrite;   // read+write together is a store
                state_d = ACCESS;
            end
            ACCESS: begin
                buf_d   = is_led ? 32'(led_q) : mem[idx];
                state_d = COMMIT;
            end
            COMMIT: begin
                if (bad) begin
                    rdata_d = 32'h0;
                    fault_d = 1'b1;
                end else if (wr_q) begin
                    if (is_led) led_d = merged[LED_W-1:0];
                end else begin
                    rdata_d = load_val;
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_we = (state_q == COMMIT) && wr_q && !bad && !is_led;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            mask_q  <= 4'h0;
            wr_q    <= 1'b0;
            buf_q   <= 32'h0;
            rdata_q <= 32'h0;
            led_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            wr_q    <= wr_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
            fault_q <= fault_d;
        end
    end

    // Array contents survive reset, but a store caught by reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) mem[idx] <= merged;
    end

    assign clk_stall = ((state_q == IDLE) && (memread | memwrite)) ||
                       (state_q == ACCESS) || (state_q == COMMIT);
    assign read_data = rdata_q;
    assign led       = led_q;
    assign mem_fault = fault_q;
endmodule

// File: tb/tb_data_mem_param.sv
// Scoreboard bench for data_mem_param: directed accesses push expected DONE-cycle
// outputs; a monitor pops and compares whenever the stall drops after an access.
module tb_data_mem_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic [3:0]  sign_mask = 4'h0;
    logic [31:0] read_data;
    logic [7:0]  led;
    logic        clk_stall;
    logic        mem_fault;

    int compared = 0;
    int errors   = 0;

    data_mem_param #(.IDX_W(10), .LED_ADDR(32'h2000), .LED_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .write_data(write_data),
        .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
        .read_data(read_data), .led(led), .clk_stall(clk_stall), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        fault;
        logic [7:0]  led;
        string       name;
    } exp_t;
    exp_t sb[$];

    // op: 0 load, 1 store, 2 load+store asserted together
    typedef struct {
        string       name;
        int          op;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  m;
        logic [31:0] rd;
        logic        fault;
        logic [7:0]  led;
    } vec_t;

    localparam logic [3:0] BS = 4'b1001, BU = 4'b0001, HS = 4'b1011, HU = 4'b0011, W = 4'b0111;

    vec_t vecs[$] = '{
        '{"ld_led_first", 0, 32'h2000, 32'h0,        W,  32'h00000000, 1'b0, 8'h00},
        '{"st_w_40",      1, 32'h40,   32'hDEADBEEF, W,  32'h00000000, 1'b0, 8'h00},
        '{"ld_bs_41",     0, 32'h41,   32'h0,        BS, 32'hFFFFFFBE, 1'b0, 8'h00},
        '{"ld_hu_42",     0, 32'h42,   32'h0,        HU, 32'h0000DEAD, 1'b0, 8'h00},
        '{"st_b_43",      1, 32'h43,   32'h00000012, BU, 32'h0000DEAD, 1'b0, 8'h00},
        '{"ld_w_40_a",    0, 32'h40,   32'h0,        W,  32'h12ADBEEF, 1'b0, 8'h00},
        '{"st_h_40",      1, 32'h40,   32'h00005678, HU, 32'h12ADBEEF, 1'b0, 8'h00},
        '{"ld_w_40_b",    0, 32'h40,   32'h0,        W,  32'h12AD5678, 1'b0, 8'h00},
        '{"st_w_0",       1, 32'h0,    32'hCAFEF00D, W,  32'h12AD5678, 1'b0, 8'h00},
        '{"st_w_led",     1, 32'h2000, 32'h000000A5, W,  32'h12AD5678, 1'b0, 8'hA5},
        '{"ld_w_0",       0, 32'h0,    32'h0,        W,  32'hCAFEF00D, 1'b0, 8'hA5},
        '{"ld_hs_2",      0, 32'h2,    32'h0,        HS, 32'hFFFFCAFE, 1'b0, 8'hA5},
        '{"ld_w_led",     0, 32'h2000, 32'h0,        W,  32'h000000A5, 1'b0, 8'hA5},
        '{"st_b_led",     1, 32'h2000, 32'h00000096, BU, 32'h000000A5, 1'b0, 8'h96},
        '{"ld_bs_led",    0, 32'h2000, 32'h0,        BS, 32'hFFFFFF96, 1'b0, 8'h96},
        '{"ld_w_42_flt",  0, 32'h42,   32'h0,        W,  32'h00000000, 1'b1, 8'h96},
        '{"ld_w_40_c",    0, 32'h40,   32'h0,        W,  32'h12AD5678, 1'b0, 8'h96},
        '{"ld_badsz_flt", 0, 32'h40,   32'h0,        4'b0010, 32'h00000000, 1'b1, 8'h96},
        '{"st_h_41_flt",  1, 32'h41,   32'h0000FFFF, HU, 32'h00000000, 1'b1, 8'h96},
        '{"ld_w_40_d",    0, 32'h40,   32'h0,        W,  32'h12AD5678, 1'b0, 8'h96},
        '{"rw_both_80",   2, 32'h80,   32'h0BADF00D, W,  32'h12AD5678, 1'b0, 8'h96},
        '{"ld_w_80",      0, 32'h80,   32'h0,        W,  32'h0BADF00D, 1'b0, 8'h96},
        '{"st_badsz_flt", 1, 32'h80,   32'hFFFFFFFF, 4'b0000, 32'h00000000, 1'b1, 8'h96},
        '{"ld_w_80_b",    0, 32'h80,   32'h0,        W,  32'h0BADF00D, 1'b0, 8'h96}
    };

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Drive one request and hold it until the stall drops, counting stall cycles.
    task automatic access(input vec_t v);
        int n;
        exp_t e;
        @(negedge clk);
        addr       = v.a;
        write_data = v.wd;
        sign_mask  = v.m;
        memread    = (v.op != 1);
        memwrite   = (v.op != 0);
        e.rd = v.rd; e.fault = v.fault; e.led = v.led; e.name = v.name;
        sb.push_back(e);
        #1;
        n = 0;
        while (clk_stall && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        memread  = 1'b0;
        memwrite = 1'b0;
        check({v.name, "_stall"}, 32'(n), 32'd3);
        @(negedge clk);
    endtask

    // Monitor: DONE is the first non-stalled cycle after a stalled one.
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && prev_stall && !clk_stall) begin
            compared++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: rd=%h fault=%b led=%h", read_data, mem_fault, led);
            end else begin
                e = sb.pop_front();
                if (read_data !== e.rd || mem_fault !== e.fault || led !== e.led) begin
                    errors++;
                    $display("FAIL %s: got rd=%h fault=%b led=%h, want rd=%h fault=%b led=%h",
                             e.name, read_data, mem_fault, led, e.rd, e.fault, e.led);
                end
            end
        end else if (mem_fault !== 1'b0) begin
            compared++;
            errors++;
            $display("FAIL fault_outside_done: mem_fault=%b", mem_fault);
        end
        prev_stall = clk_stall;
    end

    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_read_data", read_data, 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_stall", 32'(clk_stall), 32'h0);
        check("rst_fault", 32'(mem_fault), 32'h0);

        foreach (vecs[i]) access(vecs[i]);

        // Store to 0x40 aborted by reset during COMMIT must not land.
        @(negedge clk);
        addr = 32'h40; write_data = 32'h11111111; sign_mask = W; memwrite = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        memwrite = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_stall", 32'(clk_stall), 32'h0);
        check("abort_read_data", read_data, 32'h0);
        check("abort_led", 32'(led), 32'h0);
        access('{"ld_alias_1040", 0, 32'h1040, 32'h0, W, 32'h12AD5678, 1'b0, 8'h00});

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, compared=%0d", compared);
        $fatal(1, "watchdog");
    end
endmodule
